// File: rtl/round_robin_stream_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : round_robin_stream_mux                                       |
// | Description : Round-robin arbiter over N_IN valid/ready streams feeding    |
// |               one registered (data, select) output stage.                  |
// |               Build option RR_MUX_INVERT_EN: register loads inverted data. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module round_robin_stream_mux #(
    parameter int N_IN = 4,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         in_valid,
    input  logic [N_IN*W-1:0]       in_data,
    output logic [N_IN-1:0]         in_ready,
    output logic                    out_valid,
    output logic [W-1:0]            out_data,
    output logic [$clog2(N_IN)-1:0] out_sel,
    input  logic                    out_ready
);

    localparam int SW = $clog2(N_IN);
    localparam logic [SW-1:0] c_last = SW'(N_IN - 1);

    logic [SW-1:0] r_ptr;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;

    logic            w_load;
    logic            w_any;
    logic [SW-1:0]   w_gidx;
    logic [N_IN-1:0] w_grant;
    logic [W-1:0]    w_word;
    logic [W-1:0]    w_next_data;

    // Reduce ptr+i (at most 2*N_IN-1) back into 0..N_IN-1.
    function automatic logic [SW-1:0] f_wrap(input logic [SW:0] v);
        logic [SW:0] w_sub;
        w_sub = v - (SW+1)'(N_IN);
        return (v >= (SW+1)'(N_IN)) ? w_sub[SW-1:0] : v[SW-1:0];
    endfunction

    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        logic [SW-1:0] w_cand;
        w_any   = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        w_grant = '0;
        for (int i = 1; i <= N_IN; i++) begin
            w_cand = f_wrap({1'b0, r_ptr} + (SW+1)'(i));
            if (!w_any && in_valid[w_cand]) begin
                w_any  = 1'b1;
                w_gidx = w_cand;
            end
        end
        if (w_any) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    // Held low during reset so no upstream stage believes a word was taken.
    assign in_ready = (w_load && !rst) ? w_grant : '0;

    assign w_word = in_data[w_gidx*W +: W];

`ifdef RR_MUX_INVERT_EN
    assign w_next_data = ~w_word;
`else
    assign w_next_data = w_word;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= c_last;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_data  <= w_next_data;
                r_out_sel   <= w_gidx;
                r_out_valid <= 1'b1;
                r_ptr       <= w_gidx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_stream_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_round_robin_stream_mux                                    |
// | Description : Directed self-checking bench for round_robin_stream_mux.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_round_robin_stream_mux;

    localparam int N_IN = 4;
    localparam int W    = 8;

    logic            clk;
    logic            rst;
    logic [N_IN-1:0] in_valid;
    logic [N_IN*W-1:0] in_data;
    logic [N_IN-1:0] in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [1:0]      out_sel;
    logic            out_ready;

    int checks;
    int failures;

    round_robin_stream_mux #(.N_IN(N_IN), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] f_exp(input logic [W-1:0] d);
`ifdef RR_MUX_INVERT_EN
        return ~d;
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", out_data); end
        checks++; if (out_sel !== 2'd0) begin failures++; $display("FAIL reset_sel: got %0d expected 0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b expected 0000", in_ready); end
    endtask

    task automatic test_all_valid();
        logic [1:0] k;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL first_grant: got %b expected 0001", in_ready); end
        for (int i = 0; i < 8; i++) begin
            k = 2'(i % 4);
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_sel !== k) begin failures++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", i, out_sel, k); end
            checks++; if (out_data !== f_exp(8'h10 + 8'(k))) begin failures++; $display("FAIL rr_data[%0d]: got %h expected %h", i, out_data, f_exp(8'h10 + 8'(k))); end
        end
    endtask

    task automatic test_wrap();
        in_valid = 4'b0100;
        in_data  = {8'h13, 8'hA5, 8'h11, 8'h3C};
        tick();
        checks++; if (out_sel !== 2'd2 || out_data !== f_exp(8'hA5)) begin failures++; $display("FAIL only2: got sel=%0d data=%h expected sel=2 data=%h", out_sel, out_data, f_exp(8'hA5)); end
        in_valid = 4'b0101;
        tick();
        checks++; if (out_sel !== 2'd0 || out_data !== f_exp(8'h3C)) begin failures++; $display("FAIL wrap0: got sel=%0d data=%h expected sel=0 data=%h", out_sel, out_data, f_exp(8'h3C)); end
        tick();
        checks++; if (out_sel !== 2'd2 || out_data !== f_exp(8'hA5)) begin failures++; $display("FAIL back2: got sel=%0d data=%h expected sel=2 data=%h", out_sel, out_data, f_exp(8'hA5)); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready[%0d]: got %b expected 0000", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== f_exp(8'hA5)) begin failures++; $display("FAIL stall_hold[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=2 data=%h", i, out_valid, out_sel, out_data, f_exp(8'hA5)); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL release_ready: got %b expected 1000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== f_exp(8'h13)) begin failures++; $display("FAIL release_word: got v=%b sel=%0d data=%h expected v=1 sel=3 data=%h", out_valid, out_sel, out_data, f_exp(8'h13)); end
    endtask

    task automatic test_idle();
        in_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
        checks++; if (out_sel !== 2'd3 || out_data !== f_exp(8'h13)) begin failures++; $display("FAIL idle_hold: got sel=%0d data=%h expected sel=3 data=%h", out_sel, out_data, f_exp(8'h13)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid2: got %b expected 0", out_valid); end
        in_valid = 4'b1000;
        #1;
        checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL late3_ready: got %b expected 1000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd3) begin failures++; $display("FAIL late3_word: got v=%b sel=%0d expected v=1 sel=3", out_valid, out_sel); end
        in_valid = 4'b1001;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL wrap_ptr3: got %b expected 0001", in_ready); end
        tick();
        checks++; if (out_sel !== 2'd0 || out_data !== f_exp(8'h3C)) begin failures++; $display("FAIL wrap_word: got sel=%0d data=%h expected sel=0 data=%h", out_sel, out_data, f_exp(8'h3C)); end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        in_valid  = 4'hF;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL prestall_valid: got %b expected 1", out_valid); end
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin failures++; $display("FAIL midrst: got v=%b sel=%0d data=%h expected v=0 sel=0 data=00", out_valid, out_sel, out_data); end
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL postrst_ready: got %b expected 0001", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== f_exp(8'h10)) begin failures++; $display("FAIL postrst_word: got v=%b sel=%0d data=%h expected v=1 sel=0 data=%h", out_valid, out_sel, out_data, f_exp(8'h10)); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_all_valid();
        test_wrap();
        test_stall();
        test_idle();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
